bram_write_arbiter: RTL and testbench

Shares a single BRAM write port (port A) between two write requesters, e.g. an AXI4-Lite BRAM writer and a streaming capture engine, using round-robin arbitration with a bounded burst length. It sits between the requesters and the block-RAM primitive. It registers the selected beat so the BRAM sees clean, glitch-free address, data and write-enable signals one cycle after acceptance.

---
 rtl/bram_write_arbiter_if.sv | 13 +
 rtl/bram_write_arbiter.sv | 72 +++++++
 tb/tb_bram_write_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bram_write_arbiter_if.sv
// bram_write_arbiter_if: one requester's write-beat channel (valid/ready handshake) into the BRAM arbiter
interface bram_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wrdata;
  logic [DATA_WIDTH/8-1:0] we;
  logic                    valid;
  logic                    ready;
  modport master (output addr, wrdata, we, valid, input ready);
  modport slave  (input addr, wrdata, we, valid, output ready);
endinterface

// File: rtl/bram_write_arbiter.sv
// bram_write_arbiter: round-robin sharing of one BRAM write port between two requesters with bounded bursts
module bram_write_arbiter #(
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int MAX_BURST       = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  bram_write_arbiter_if.slave          s0,
  bram_write_arbiter_if.slave          s1,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we,
  output logic [1:0]                   grant
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state, state_n;
  logic last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic hs0, hs1, at_max;
  assign hs0    = state == GRANT0 && s0.valid;
  assign hs1    = state == GRANT1 && s1.valid;
  assign at_max = cnt == CW'(MAX_BURST - 1);
  assign bram_porta_clk = aclk;
  assign bram_porta_rst = ~aresetn;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    case (state)
      IDLE:    state_n = s0.valid && (!s1.valid || last) ? GRANT0 : s1.valid ? GRANT1 : IDLE;
      GRANT0:  state_n = !s0.valid ? (s1.valid ? GRANT1 : IDLE) : (at_max && s1.valid ? GRANT1 : GRANT0);
      GRANT1:  state_n = !s1.valid ? (s0.valid ? GRANT0 : IDLE) : (at_max && s0.valid ? GRANT0 : GRANT1);
      default: state_n = IDLE;
    endcase
    cnt_n  = state_n != state || state_n == IDLE || at_max ? '0 : cnt + 1'b1;
    last_n = state_n == GRANT0 ? 1'b0 : state_n == GRANT1 ? 1'b1 : last;
  end
  always_comb begin
    s0.ready = state == GRANT0;
    s1.ready = state == GRANT1;
    grant    = {state == GRANT1, state == GRANT0};
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bram_porta_addr   <= '0;
      bram_porta_wrdata <= '0;
      bram_porta_we     <= '0;
    end else if (hs0) begin
      bram_porta_addr   <= s0.addr;
      bram_porta_wrdata <= s0.wrdata;
      bram_porta_we     <= s0.we;
    end else if (hs1) begin
      bram_porta_addr   <= s1.addr;
      bram_porta_wrdata <= s1.wrdata;
      bram_porta_we     <= s1.we;
    end else begin
      bram_porta_we     <= '0;
    end
  end
endmodule

// File: tb/tb_bram_write_arbiter.sv
// tb_bram_write_arbiter: directed checks of reset, single beat, saturated fairness, drop handover, lone burst and async reset
module tb_bram_write_arbiter;
  logic aclk, aresetn;
  logic bram_porta_clk, bram_porta_rst;
  logic [9:0] bram_porta_addr;
  logic [31:0] bram_porta_wrdata;
  logic [3:0] bram_porta_we;
  logic [1:0] grant;
  int errors = 0, checks = 0, n0 = 0, n1 = 0;
  bram_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) s0 ();
  bram_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) s1 ();
  bram_write_arbiter #(.BRAM_DATA_WIDTH(32), .BRAM_ADDR_WIDTH(10), .MAX_BURST(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .s0(s0), .s1(s1),
    .bram_porta_clk(bram_porta_clk), .bram_porta_rst(bram_porta_rst),
    .bram_porta_addr(bram_porta_addr), .bram_porta_wrdata(bram_porta_wrdata),
    .bram_porta_we(bram_porta_we), .grant(grant)
  );
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic h0, h1;
    h0 = s0.valid & s0.ready;
    h1 = s1.valid & s1.ready;
    @(posedge aclk);
    #1;
    if (h0) begin n0++; s0.wrdata = 32'h100 + 32'(n0); s0.addr = 10'(n0); end
    if (h1) begin n1++; s1.wrdata = 32'h200 + 32'(n1); s1.addr = 10'h80 + 10'(n1); end
  endtask
  task automatic do_reset();
    aresetn = 1'b0;
    n0 = 0; n1 = 0;
    s0.valid = 1'b0; s0.we = 4'hF; s0.wrdata = 32'h100; s0.addr = '0;
    s1.valid = 1'b0; s1.we = 4'hF; s1.wrdata = 32'h200; s1.addr = 10'h80;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask
  initial begin
    do_reset();
    aresetn = 1'b0;
    s0.valid = 1'b1;
    s1.valid = 1'b1;
    @(posedge aclk);
    #1;
    chk("rst_s0_ready", s0.ready, 0);
    chk("rst_s1_ready", s1.ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_we", bram_porta_we, 0);
    chk("rst_addr", bram_porta_addr, 0);
    chk("rst_data", bram_porta_wrdata, 0);
    chk("rst_porta_rst", bram_porta_rst, 1);
    aresetn = 1'b1;
    #1 chk("rel_porta_rst", bram_porta_rst, 0);
    tick();
    chk("rel_s0_ready", s0.ready, 1);
    chk("rel_s1_ready", s1.ready, 0);
    chk("rel_grant", grant, 1);
    for (int n = 2; n <= 13; n++) begin
      tick();
      chk("sat_we", bram_porta_we, 4'hF);
      chk("sat_data", bram_porta_wrdata, n <= 5 ? 32'h100 + 32'(n - 2) : n <= 9 ? 32'h200 + 32'(n - 6) : 32'h104 + 32'(n - 10));
      chk("sat_grant", grant, ((n - 1) / 4) % 2 == 1 ? 2'b10 : 2'b01);
    end
    do_reset();
    s1.addr = 10'h005; s1.wrdata = 32'hDEADBEEF; s1.we = 4'hF; s1.valid = 1'b1;
    tick();
    chk("one_s1_ready", s1.ready, 1);
    chk("one_grant", grant, 2'b10);
    chk("one_we_pre", bram_porta_we, 0);
    tick();
    chk("one_we", bram_porta_we, 4'hF);
    chk("one_addr", bram_porta_addr, 10'h005);
    chk("one_data", bram_porta_wrdata, 32'hDEADBEEF);
    s1.valid = 1'b0;
    tick();
    chk("one_we_post", bram_porta_we, 0);
    chk("one_addr_hold", bram_porta_addr, 10'h005);
    chk("one_data_hold", bram_porta_wrdata, 32'hDEADBEEF);
    chk("one_grant_idle", grant, 0);
    do_reset();
    s0.valid = 1'b1;
    s1.valid = 1'b1;
    tick();
    chk("drop_grant0", grant, 2'b01);
    tick();
    chk("drop_b0", bram_porta_wrdata, 32'h100);
    tick();
    chk("drop_b1", bram_porta_wrdata, 32'h101);
    s0.valid = 1'b0;
    tick();
    chk("drop_bubble_we", bram_porta_we, 0);
    chk("drop_s1_ready", s1.ready, 1);
    chk("drop_grant1", grant, 2'b10);
    s0.valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drop_s1_we", bram_porta_we, 4'hF);
      chk("drop_s1_data", bram_porta_wrdata, 32'h200 + 32'(k));
      chk("drop_s1_grant", grant, k == 3 ? 2'b01 : 2'b10);
    end
    do_reset();
    s0.valid = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("lone_grant", grant, 2'b01);
      chk("lone_we", bram_porta_we, 4'hF);
      chk("lone_data", bram_porta_wrdata, 32'h100 + 32'(k));
    end
    s0.valid = 1'b0;
    tick();
    chk("lone_end_we", bram_porta_we, 0);
    chk("lone_end_grant", grant, 0);
    do_reset();
    s1.valid = 1'b1;
    repeat (4) tick();
    chk("ar_we_pre", bram_porta_we, 4'hF);
    chk("ar_data_pre", bram_porta_wrdata, 32'h202);
    chk("ar_ready_pre", s1.ready, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("ar_we", bram_porta_we, 0);
    chk("ar_s1_ready", s1.ready, 0);
    chk("ar_grant", grant, 0);
    chk("ar_addr", bram_porta_addr, 0);
    s1.valid = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    tick();
    chk("ar_idle_grant", grant, 0);
    chk("ar_idle_ready", s1.ready, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
